bbpd_majority_voter: RTL
========================

Name: bbpd_majority_voter

Overview:
- Bang-bang (Alexander) phase detector with decimating majority voter.
- It is the producer of the Up/Dn pair consumed by the CDR digital loop filter.
- It takes one data sample and one edge sample per UI, classifies each UI as early, late, no-transition or invalid, and accumulates votes over a fixed window.
- At the end of each window it emits at most one registered Up or Dn pulse, to lower loop-filter update rate and jitter.

Parameters:
- VOTE_LEN, 8: number of counted sample cycles per vote window; valid range is 2..(2**CNT_W - 1).
- CNT_W, 4: width of the window sample counter.
- THRESH, 1: minimum |late - early| needed to issue a pulse; valid range is 1..VOTE_LEN.
- INV_W, 8: width of the saturating invalid-pattern counter.

Ports:
- clk  in  1  sample-rate clock
- rst_n  in  1  asynchronous reset, active low
- en  in  1  data_smp/edge_smp valid this cycle
- data_smp  in  1  data sample at UI centre (B)
- edge_smp  in  1  edge sample between previous and current data (T)
- Up  out  1  late decision, one-cycle pulse (filter case 2'b10)
- Dn  out  1  early decision, one-cycle pulse (filter case 2'b01)
- win_done  out  1  one-cycle pulse at every window close, regardless of decision
- inv_cnt  out  INV_W  saturating count of invalid patterns since reset

Behaviour:
- Reset (async, rst_n=0): all state is cleared.
  - Up=0, Dn=0, win_done=0, inv_cnt=0.
  - prev_data=0, prev_valid=0, sample count=0, net=0.
  - Deassertion takes effect on the next clk edge. Reset mid-window discards the partial window and emits no pulse.
- en=0 cycle: no state change. Up, Dn and win_done go 0. prev_data is held.
- First en after reset (prev_valid=0):
  - Only loads prev_data<=data_smp and sets prev_valid=1.
  - Casts no vote and does not advance the count.
- Every en cycle with prev_valid=1 forms A=prev_data, T=edge_smp, B=data_smp, then sets prev_data<=data_smp.
- Classification, {A,T,B}:
  - 000, 111: no transition; vote 0.
  - 001, 110: early (T==A); vote -1.
  - 011, 100: late (T==B); vote +1.
  - 010, 101: invalid; vote 0; inv_cnt+1, saturating at 2**INV_W-1.
- Every classified sample, including no-transition and invalid, advances the window count by 1.
- net is a signed accumulator of CNT_W+1 bits and cannot overflow for legal VOTE_LEN.
- Window close: the en cycle where count reaches VOTE_LEN, with that cycle's vote included (net_final).
  - Next cycle, Up=1 if net_final >= THRESH.
  - Next cycle, Dn=1 if net_final <= -THRESH.
  - Otherwise both stay 0.
  - win_done=1 in that same next cycle.
  - count and net restart at 0. The closing sample's vote belongs to the closing window only.
- Latency: Up/Dn/win_done are registered and assert exactly 1 clk after the closing en edge. They are high for exactly 1 cycle, even if en stays high.
- Up and Dn are never simultaneously 1.
- Back-to-back windows are allowed. With en held high, a pulse appears every VOTE_LEN cycles.
- prev_data persists across window boundaries, so there are no lost transitions between windows.

Test Plan:
1. Hold rst_n=0 with random inputs -> Up=Dn=win_done=0, inv_cnt=0. Release; a first en with data_smp=1 produces no pulse and no count.
2. en=1, data alternating 0,1,0,1,... with edge_smp=A each cycle, VOTE_LEN=8 -> after 1 priming + 8 samples, Dn=1 and win_done=1 for exactly one cycle, Up=0. This repeats every 8 cycles.
3. Same alternating data with edge_smp=B -> Up=1 one cycle after the 8th counted sample, Dn=0.
4. 4 early + 4 late in one window -> win_done=1, Up=Dn=0. Repeat with 5 late + 3 early and THRESH=3 -> no pulse. With THRESH=2 -> Up pulse.
5. Feed pattern A=0,T=1,B=0 three times -> inv_cnt=3, the samples still count toward the window, no vote. With INV_W=2 and 5 invalid samples -> inv_cnt sticks at 3.
6. Late pattern with en gaps (en=1,0,0,1,...) -> Up appears after the 8th en-high sample, not after 8 clocks. Assert rst_n=0 after 5 samples -> no pulse, and a fresh window after release requires priming plus 8 samples.

Source files
------------

// File: rtl/bbpd_majority_voter.sv
// ---------------------------------------------------------------------------
// bbpd_majority_voter
//
// Bang-bang (Alexander) phase detector followed by a decimating majority
// voter. Each valid UI supplies one data sample (B) and one edge sample (T).
// Together with the previous data sample (A), the pair is classified as
// early, late, no-transition or invalid. Votes accumulate over VOTE_LEN
// classified samples. When a window closes, at most one registered Up or Dn
// pulse is issued to the CDR loop filter.
//
// Handshake: en qualifies data_smp/edge_smp in the cycle it is high. There
// is no back-pressure; every en-high cycle is consumed.
//
// Ports:
//   clk      - sample-rate clock
//   rst_n    - asynchronous reset, active low
//   en       - data_smp/edge_smp valid this cycle
//   data_smp - data sample at UI centre (B)
//   edge_smp - edge sample between previous and current data (T)
//   Up       - late decision, one-cycle pulse
//   Dn       - early decision, one-cycle pulse
//   win_done - one-cycle pulse at every window close
//   inv_cnt  - saturating count of invalid {A,T,B} patterns since reset
// ---------------------------------------------------------------------------
module bbpd_majority_voter #(
  parameter int VOTE_LEN = 8,
  parameter int CNT_W    = 4,
  parameter int THRESH   = 1,
  parameter int INV_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data_smp,
  input  logic             edge_smp,
  output logic             Up,
  output logic             Dn,
  output logic             win_done,
  output logic [INV_W-1:0] inv_cnt
);

  localparam logic        [CNT_W-1:0] LAST_CNT = CNT_W'(VOTE_LEN - 1);
  localparam logic signed [CNT_W:0]   THR_POS  = (CNT_W + 1)'(THRESH);
  localparam logic signed [CNT_W:0]   THR_NEG  = (CNT_W + 1)'(-THRESH);

  logic                    prev_data;
  logic                    prev_valid;
  logic        [CNT_W-1:0] cnt;
  logic signed [CNT_W:0]   net;

  logic                    is_trans;
  logic                    is_early;
  logic                    is_late;
  logic                    is_inv;
  logic signed [CNT_W:0]   vote;
  logic signed [CNT_W:0]   net_sum;
  logic                    counted;
  logic                    closing;

  // Classification of {A,T,B}. A transition is A!=B. The edge sample then
  // shows which side of the crossing the clock sits on. T==A means the edge
  // was sampled before the crossing (early). T==B means after it (late).
  // Without a transition, T differing from both samples is a glitch.
  always_comb begin
    is_trans = prev_data ^ data_smp;
    is_early = is_trans & (edge_smp == prev_data);
    is_late  = is_trans & (edge_smp == data_smp);
    is_inv   = ~is_trans & (edge_smp != prev_data);
    vote     = '0;
    if (is_late)
      vote = (CNT_W + 1)'(1);
    else if (is_early)
      vote = (CNT_W + 1)'(-1);
    net_sum  = net + vote;
    counted  = en & prev_valid;
    closing  = counted & (cnt == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_data  <= 1'b0;
      prev_valid <= 1'b0;
      cnt        <= '0;
      net        <= '0;
      Up         <= 1'b0;
      Dn         <= 1'b0;
      win_done   <= 1'b0;
      inv_cnt    <= '0;
    end else begin
      // Decision outputs are single-cycle pulses by construction.
      Up       <= 1'b0;
      Dn       <= 1'b0;
      win_done <= 1'b0;
      if (en) begin
        // prev_data carries across window boundaries. The first sample of
        // a window is therefore classified against the last sample of the
        // previous window.
        prev_data  <= data_smp;
        prev_valid <= 1'b1;
        if (prev_valid) begin
          if (is_inv && (inv_cnt != {INV_W{1'b1}}))
            inv_cnt <= inv_cnt + 1'b1;
          if (closing) begin
            // The closing sample's vote is included here and is not carried
            // into the next window.
            cnt      <= '0;
            net      <= '0;
            win_done <= 1'b1;
            Up       <= (net_sum >= THR_POS);
            Dn       <= (net_sum <= THR_NEG);
          end else begin
            cnt <= cnt + 1'b1;
            net <= net_sum;
          end
        end
      end
    end
  end

endmodule
